xmr_pipe_chain: RTL and testbench
=================================

Name: xmr_pipe_chain

Overview:
- Elastic, parameterised register chain that carries one eliminated cross-module-reference signal from its source module to the consuming module.
- XMR elimination inserts one instance per rewritten reference, between the driving register (e.g. a toggling status bit in a submodule) and the consumer's assign.
- Each stage is a valid/ready pipeline register, so downstream backpressure never loses or duplicates a sample.

Parameters:
- WIDTH, 1, data width of the carried signal in bits (1..64).
- DEPTH, 2, number of register stages (1..8); DEPTH=0 is illegal and is rejected by an elaboration-time check.

Ports:
- clk  input  1  single clock for all stages.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous flush; invalidates every stage.
- in_valid  input  1  source sample valid.
- in_data  input  WIDTH  source sample.
- in_ready  output  1  chain accepts in_data this cycle.
- out_valid  output  1  last stage holds a valid sample.
- out_data  output  WIDTH  last-stage data.
- out_ready  input  1  consumer accepts out_data this cycle.
- occ  output  $clog2(DEPTH+1)  number of valid stages.
- par_err  output  1  sticky parity error (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Stages are numbered 0 (input side) to DEPTH-1 (output side). Each stage holds valid_q[i] and data_q[i].
- Reset state: all valid_q = 0, occ = 0, par_err = 0, out_valid = 0. After reset, in_ready = 1 when flush = 0. data_q is also reset to 0, so out_data = 0.
- Stage advance condition: adv[i] = !valid_q[i] | adv[i+1]. The last stage uses adv[DEPTH-1] = !valid_q[DEPTH-1] | out_ready.
- The ready chain is combinational; no bubble insertion. Throughput is 1 sample/cycle with out_ready held high.
- in_ready = adv[0] & !flush.
- On adv[i]:
  - valid_q[i] <= upstream valid.
  - data_q[i] <= upstream data, but only when upstream valid = 1; otherwise data is held (no clock-gating requirement).
- Latency: a sample accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles from the in_valid cycle, provided there is no stall.
- Stall: with out_ready = 0, stages fill from the output side. in_ready drops only when all DEPTH stages are valid. Order is strictly preserved.
- Simultaneous fill/drain: when full and out_ready = 1, in_ready = 1 in the same cycle. The chain shifts and accepts, and occ stays at DEPTH.
- occ update: +1 on an input transfer only, -1 on an output transfer only, unchanged when both or neither occur. It never exceeds DEPTH or drops below 0.
- flush:
  - Next edge: all valid_q = 0 and occ = 0.
  - in_ready = 0 in the flush cycle, so a concurrent in_valid is NOT accepted.
  - An out transfer in the flush cycle (out_valid & out_ready) still counts as delivered.
  - data_q is unchanged.
- rst wins over flush. rst mid-stream discards all in-flight samples, with no partial output.
- out_data is undefined-but-stable (last loaded value) when out_valid = 0. The bench must not check it then.

Optional Feature:
- Macro: XMR_PIPE_PARITY_EN.
- Defined:
  - Each stage stores an extra even-parity bit computed from in_data at stage 0.
  - The output stage recomputes parity.
  - On any cycle with out_valid = 1 and a mismatch, par_err sets and stays set until rst. flush does not clear it.
  - A test-only force of a stored bit must raise par_err one cycle after the corrupted sample reaches the output.
- Not defined: no parity storage, par_err tied to 0. Port list is identical in both builds.

Test Plan:
- Reset and stream (WIDTH=8, DEPTH=3): rst for 2 cycles, then in_data 0x01,0x02,0x03 on consecutive cycles with out_ready = 1. Required: occ = 0 and in_ready = 1 after reset, out_valid = 0 during reset; out_data 0x01 at cycle 3 after first accept, then 0x02, 0x03 back-to-back; occ peaks at 3.
- Backpressure (DEPTH=3): out_ready = 0, push 0xA0..0xA4. Required: only 0xA0..0xA2 accepted, in_ready = 0 with occ = 3. Release out_ready: outputs 0xA0,0xA1,0xA2,0xA3,0xA4 in order, no duplicates.
- Full with simultaneous push/pop: full chain, out_ready = 1, in_valid = 1 for 5 cycles. Required: in_ready = 1 every cycle and occ constant at 3.
- Flush (DEPTH=3): occ = 2, assert flush with in_valid = 1 (data 0x55). Required: in_ready = 0 in that cycle; next cycle occ = 0 and out_valid = 0; 0x55 never appears at the output.
- Reset mid-operation: occ = 3, rst for 1 cycle while flush = 1. Required: occ = 0, out_valid = 0, par_err = 0; the next pushed sample 0x7E emerges after DEPTH cycles.
- Parity (with XMR_PIPE_PARITY_EN): push 0x0F, force stage-1 bit 0 to flip. Required: par_err = 1 on the cycle after 0x0E reaches out_valid; it stays 1 through flush and clears only on rst.

Source files
------------

// File: rtl/xmr_pipe_chain.sv
// Elastic valid/ready register chain carrying one eliminated cross-module reference.
// Optional per-stage even parity with a sticky error flag: define XMR_PIPE_PARITY_EN.
module xmr_pipe_chain #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   occ,
   output logic                         par_err
);

   localparam int unsigned OCC_W = $clog2(DEPTH+1);

   if (DEPTH < 1 || DEPTH > 8 || WIDTH < 1 || WIDTH > 64) begin : g_bad_cfg
      $error("xmr_pipe_chain: DEPTH must be 1..8 and WIDTH 1..64");
   end

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] adv;
   logic [DEPTH:0]   chain_v;
   logic             adv_run;
   logic [WIDTH-1:0] data_q  [DEPTH];
   logic [WIDTH-1:0] data_d  [DEPTH];
   logic [WIDTH-1:0] up_data [DEPTH];
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             in_fire, out_fire;

   // Ready ripples from the output side back to stage 0 in one cycle.
   always_comb begin
      adv_run = !valid_q[DEPTH-1] | out_ready;
      adv = '0;
      adv[DEPTH-1] = adv_run;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         adv_run = !valid_q[DEPTH-1-k] | adv_run;
         adv[DEPTH-1-k] = adv_run;
      end
   end

   assign in_ready  = adv[0] & !flush;
   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];
   assign occ       = occ_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign chain_v   = {valid_q, in_fire};

   always_comb begin
      up_data[0] = in_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         up_data[k] = data_q[k-1];
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (adv[k]) begin
            valid_d[k] = chain_v[k];
         end
         if (adv[k] && chain_v[k] && !flush) begin
            data_d[k] = up_data[k];
         end
      end
      if (flush) begin
         valid_d = '0;
      end
   end

   always_comb begin
      occ_d = occ_q;
      case ({in_fire, out_fire})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
      if (flush) begin
         occ_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         occ_q   <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

`ifdef XMR_PIPE_PARITY_EN
   logic [DEPTH-1:0] par_q, par_d;
   logic [DEPTH:0]   chain_p;
   logic             par_err_q;

   assign chain_p = {par_q, ^in_data};

   // Parity travels with its data word under exactly the same load condition.
   always_comb begin
      par_d = par_q;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (adv[k] && chain_v[k] && !flush) begin
            par_d[k] = chain_p[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         par_q     <= '0;
         par_err_q <= 1'b0;
      end else begin
         par_q     <= par_d;
         par_err_q <= par_err_q | (out_valid & ((^out_data) != par_q[DEPTH-1]));
      end
   end

   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_xmr_pipe_chain.sv
// Scoreboard bench for xmr_pipe_chain (WIDTH=8, DEPTH=3); parity case needs XMR_PIPE_PARITY_EN.
module tb_xmr_pipe_chain;

   logic       clk = 1'b0;
   logic       rst, flush, in_valid, out_ready;
   logic [7:0] in_data, out_data;
   logic       in_ready, out_valid, par_err;
   logic [1:0] occ;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb [$];

   xmr_pipe_chain #(.WIDTH(8), .DEPTH(3)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .occ(occ), .par_err(par_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: every output transfer must match the head of the scoreboard.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %0h, expected no output", out_data);
         end else begin
            logic [7:0] exp;
            exp = sb.pop_front();
            if (out_data !== exp) begin
               errors++;
               $display("FAIL out_data: got %0h expected %0h", out_data, exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic exp_acc);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
      if (exp_acc) sb.push_back(d);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (sb.size() == 0 && !out_valid) break;
         step();
      end
      chk({name, "_sb_empty"}, sb.size(), 0);
      chk({name, "_occ0"}, {30'd0, occ}, 0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step();
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      step();
      chk("rst_out_valid2", {31'd0, out_valid}, 0);
      chk("rst_occ", {30'd0, occ}, 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("rst_out_data", {24'd0, out_data}, 0);
      chk("rst_par_err", {31'd0, par_err}, 0);

      // Stream with latency check.
      out_ready = 1'b1;
      push(8'h01, 1'b1);
      chk("lat_v1", {31'd0, out_valid}, 0);
      chk("occ1", {30'd0, occ}, 1);
      push(8'h02, 1'b1);
      chk("lat_v2", {31'd0, out_valid}, 0);
      chk("occ2", {30'd0, occ}, 2);
      push(8'h03, 1'b1);
      chk("lat_v3", {31'd0, out_valid}, 1);
      chk("occ_peak", {30'd0, occ}, 3);
      step();
      chk("occ_drain", {30'd0, occ}, 2);
      drain("stream");

      // Backpressure.
      out_ready = 1'b0;
      push(8'hA0, 1'b1);
      push(8'hA1, 1'b1);
      push(8'hA2, 1'b1);
      chk("bp_occ_full", {30'd0, occ}, 3);
      push(8'hA3, 1'b0);
      push(8'hA3, 1'b0);
      chk("bp_occ_held", {30'd0, occ}, 3);
      out_ready = 1'b1;
      push(8'hA3, 1'b1);
      push(8'hA4, 1'b1);
      drain("bp");

      // Full chain, simultaneous push and pop.
      out_ready = 1'b0;
      push(8'hB0, 1'b1);
      push(8'hB1, 1'b1);
      push(8'hB2, 1'b1);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 8'hB3 + 8'(k);
         #1;
         chk("pp_in_ready", {31'd0, in_ready}, 1);
         chk("pp_occ", {30'd0, occ}, 3);
         sb.push_back(in_data);
         step();
      end
      drain("pushpop");

      // Flush with a concurrent input offer.
      out_ready = 1'b0;
      push(8'hC0, 1'b1);
      push(8'hC1, 1'b1);
      chk("fl_occ2", {30'd0, occ}, 2);
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      #1;
      chk("fl_in_ready", {31'd0, in_ready}, 0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      chk("fl_occ0", {30'd0, occ}, 0);
      chk("fl_out_valid", {31'd0, out_valid}, 0);
      out_ready = 1'b1;
      repeat (5) step();
      chk("fl_no_output", {31'd0, out_valid}, 0);

      // Reset mid-operation while flush is also high.
      out_ready = 1'b0;
      push(8'hD0, 1'b1);
      push(8'hD1, 1'b1);
      push(8'hD2, 1'b1);
      chk("mr_occ3", {30'd0, occ}, 3);
      rst = 1'b1; flush = 1'b1;
      step();
      rst = 1'b0; flush = 1'b0;
      sb.delete();
      chk("mr_occ0", {30'd0, occ}, 0);
      chk("mr_out_valid", {31'd0, out_valid}, 0);
      chk("mr_par_err", {31'd0, par_err}, 0);
      out_ready = 1'b1;
      push(8'h7E, 1'b1);
      chk("mr_lat1", {31'd0, out_valid}, 0);
      step();
      chk("mr_lat2", {31'd0, out_valid}, 0);
      step();
      chk("mr_lat3", {31'd0, out_valid}, 1);
      drain("midrst");

`ifdef XMR_PIPE_PARITY_EN
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h0F;
      #1;
      chk("par_in_ready", {31'd0, in_ready}, 1);
      sb.push_back(8'h0E);
      step();
      in_valid = 1'b0;
      step();
      force dut.data_q[1] = 8'h0E;
      step();
      release dut.data_q[1];
      chk("par_out_valid", {31'd0, out_valid}, 1);
      chk("par_err_pre", {31'd0, par_err}, 0);
      step();
      chk("par_err_set", {31'd0, par_err}, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("par_err_flush", {31'd0, par_err}, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("par_err_rst", {31'd0, par_err}, 0);
      chk("par_sb_empty", sb.size(), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
